// File: rtl/if_fetch_unit.sv
// Purpose: instruction fetch unit; owns the PC, reads instruction memory, presents PC+4/instruction to IF register.
// Latency: word returned with imem_rdy in cycle N is presented from cycle N+1; branch target fetched from N+1.
// Backpressure: freeze holds the output; one extra response lands in a skid slot, then imem_req drops until release.
//
// Ports:
//   clk, rst (async, active-low)     clock and reset
//   freeze                           downstream stall, hold current output pair
//   branch_taken, branch_addr        single-cycle redirect from execute
//   imem_req, imem_addr              read request and word-aligned address (addr = fetch pc)
//   imem_rdy, imem_rdata             memory response for imem_addr in this cycle
//   PC_out, Instruction_out          presented pc+4 and instruction, zeroed when invalid
//   inst_valid                       outputs carry a real fetched instruction
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_out,
    output logic [31:0] Instruction_out,
    output logic        inst_valid
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t      state_q,    state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] out_pc_q,   out_pc_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] skid_pc_q,  skid_pc_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic        skid_valid_q, skid_valid_d;

    logic        slot_free;
    logic [31:0] pc_plus4;

    // Redirect targets are word aligned; the low address bits carry no meaning.
    logic [1:0]  unused_branch_lsbs;
    assign unused_branch_lsbs = branch_addr[1:0];

    assign imem_req  = (state_q == S_FETCH) && rst;
    assign imem_addr = fetch_pc_q;
    assign pc_plus4  = fetch_pc_q + 32'd4;   // wraps modulo 2^32
    // The output slot can take a new word if it is empty or is being consumed now.
    assign slot_free = !out_valid_q || !freeze;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        out_pc_d     = out_pc_q;
        out_inst_d   = out_inst_q;
        out_valid_d  = out_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_inst_d  = skid_inst_q;
        skid_valid_d = skid_valid_q;

        if (branch_taken) begin
            // Redirect beats freeze and discards any response arriving this cycle.
            fetch_pc_d   = {branch_addr[31:2], 2'b00};
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            state_d      = S_FETCH;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (imem_rdy && imem_req) begin
                        fetch_pc_d = pc_plus4;
                        if (slot_free) begin
                            out_pc_d    = pc_plus4;
                            out_inst_d  = imem_rdata;
                            out_valid_d = 1'b1;
                        end else begin
                            skid_pc_d    = pc_plus4;
                            skid_inst_d  = imem_rdata;
                            skid_valid_d = 1'b1;
                            state_d      = S_HOLD;
                        end
                    end else if (!freeze) begin
                        // Consumed word is not replaced; present a bubble.
                        out_valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!freeze) begin
                        out_pc_d     = skid_pc_q;
                        out_inst_d   = skid_inst_q;
                        out_valid_d  = skid_valid_q;
                        skid_valid_d = 1'b0;
                        state_d      = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_FETCH;
            fetch_pc_q   <= RESET_PC;
            out_pc_q     <= 32'd0;
            out_inst_q   <= 32'd0;
            out_valid_q  <= 1'b0;
            skid_pc_q    <= 32'd0;
            skid_inst_q  <= 32'd0;
            skid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            out_pc_q     <= out_pc_d;
            out_inst_q   <= out_inst_d;
            out_valid_q  <= out_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_inst_q  <= skid_inst_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign inst_valid      = out_valid_q;
    assign PC_out          = out_valid_q ? out_pc_q   : 32'd0;
    assign Instruction_out = out_valid_q ? out_inst_q : 32'd0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Purpose: self-checking bench for if_fetch_unit with directed scenarios and a random phase.
// Latency: reference model advances on every rising edge; outputs compared at the falling edge.
// Backpressure: freeze, wait states and redirects are driven directly by the stimulus.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy;
    logic [31:0] imem_rdata;
    logic [31:0] PC_out;
    logic [31:0] Instruction_out;
    logic        inst_valid;

    logic [31:0] salt = 32'd0;

    int checks = 0;
    int errors = 0;

    // Memory content is a simple function of the address.
    assign imem_rdata = imem_addr ^ salt;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_addr     (branch_addr),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rdy        (imem_rdy),
        .imem_rdata      (imem_rdata),
        .PC_out          (PC_out),
        .Instruction_out (Instruction_out),
        .inst_valid      (inst_valid)
    );

    always #5 clk = ~clk;

    // Reference model: the fetch unit is a FIFO of at most two fetched words
    // (presented + one buffered). A request is issued whenever it has room.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc = 32'h0000_0000;
    endtask

    task automatic model_step();
        bit had;
        bit req;
        had = (mq.size() > 0);
        req = (mq.size() < 2);
        if (branch_taken) begin
            mq.delete();
            m_pc = {branch_addr[31:2], 2'b00};
        end else begin
            if (had && !freeze) void'(mq.pop_front());
            if (req && imem_rdy) begin
                mq.push_back('{pc: m_pc + 32'd4, inst: m_pc ^ salt});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic check_model();
        bit v;
        v = (mq.size() > 0);
        chk("m_valid", {31'd0, inst_valid}, {31'd0, v});
        chk("m_pc_out", PC_out, v ? mq[0].pc : 32'd0);
        chk("m_inst", Instruction_out, v ? mq[0].inst : 32'd0);
        chk("m_req", {31'd0, imem_req}, {31'd0, (rst === 1'b1) && (mq.size() < 2)});
        chk("m_addr", imem_addr, m_pc);
    endtask

    // One clock: compare at the falling edge, advance the model at the rising
    // edge, return 1 time unit after the edge so inputs can be changed safely.
    task automatic cyc();
        @(negedge clk);
        check_model();
        @(posedge clk);
        if (rst) model_step();
        #1;
    endtask

    initial begin
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0;
        branch_addr = 32'd0; imem_rdy = 1'b0;
        model_reset();
        #2;
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_pc", PC_out, 32'd0);
        chk("rst_inst", Instruction_out, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        cyc();
        cyc();
        rst = 1'b1;

        // Zero-wait memory returning word = address.
        imem_rdy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("zw_pc", PC_out, 32'(4 * k));
            chk("zw_inst", Instruction_out, 32'(4 * (k - 1)));
            chk("zw_valid", {31'd0, inst_valid}, 32'd1);
        end

        // Two wait states per read: valid once every three cycles.
        for (int i = 0; i < 9; i++) begin
            imem_rdy = (i % 3 == 2);
            cyc();
            chk("ws_valid", {31'd0, inst_valid}, {31'd0, (i % 3 == 2)});
            chk("ws_pc", PC_out, (i % 3 == 2) ? 32'(20 + 4 * (i / 3)) : 32'd0);
            chk("ws_inst", Instruction_out, (i % 3 == 2) ? 32'(16 + 4 * (i / 3)) : 32'd0);
        end

        // Freeze for 5 cycles while presenting 28/24.
        imem_rdy = 1'b1;
        freeze = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("frz_pc", PC_out, 32'd28);
            chk("frz_inst", Instruction_out, 32'd24);
            chk("frz_valid", {31'd0, inst_valid}, 32'd1);
            chk("frz_req", {31'd0, imem_req}, 32'd0);
        end
        freeze = 1'b0;
        cyc();
        chk("rel_pc0", PC_out, 32'd32);
        chk("rel_inst0", Instruction_out, 32'd28);
        chk("rel_req", {31'd0, imem_req}, 32'd1);
        cyc();
        chk("rel_pc1", PC_out, 32'd36);
        chk("rel_inst1", Instruction_out, 32'd32);

        // Branch with a simultaneous response: response is discarded.
        branch_taken = 1'b1; branch_addr = 32'h0000_0103;
        cyc();
        branch_taken = 1'b0;
        chk("br_valid", {31'd0, inst_valid}, 32'd0);
        chk("br_inst", Instruction_out, 32'd0);
        chk("br_addr", imem_addr, 32'h100);
        cyc();
        chk("br_pc", PC_out, 32'h104);
        chk("br_tinst", Instruction_out, 32'h100);

        // Branch while in HOLD with freeze still asserted.
        freeze = 1'b1;
        cyc();
        chk("hb_req0", {31'd0, imem_req}, 32'd0);
        chk("hb_pc0", PC_out, 32'h104);
        branch_taken = 1'b1; branch_addr = 32'h0000_0200;
        cyc();
        branch_taken = 1'b0;
        chk("hb_valid", {31'd0, inst_valid}, 32'd0);
        chk("hb_addr", imem_addr, 32'h200);
        chk("hb_req1", {31'd0, imem_req}, 32'd1);
        cyc();
        chk("hb_pc1", PC_out, 32'h204);
        chk("hb_inst1", Instruction_out, 32'h200);
        freeze = 1'b0;

        // Address wrap from the top word to zero.
        branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFF;
        cyc();
        branch_taken = 1'b0;
        chk("wr_addr0", imem_addr, 32'hFFFF_FFFC);
        cyc();
        chk("wr_pc0", PC_out, 32'd0);
        chk("wr_inst0", Instruction_out, 32'hFFFF_FFFC);
        chk("wr_addr1", imem_addr, 32'd0);
        cyc();
        chk("wr_pc1", PC_out, 32'd4);
        chk("wr_inst1", Instruction_out, 32'd0);

        // Reset while waiting on a read at pc=40 with a held valid output.
        branch_taken = 1'b1; branch_addr = 32'd36;
        cyc();
        branch_taken = 1'b0;
        cyc();
        imem_rdy = 1'b0; freeze = 1'b1;
        cyc();
        chk("rm_addr", imem_addr, 32'd40);
        chk("rm_pc", PC_out, 32'd40);
        #1;
        rst = 1'b0;
        #1;
        model_reset();
        chk("rm_valid", {31'd0, inst_valid}, 32'd0);
        chk("rm_pc0", PC_out, 32'd0);
        chk("rm_inst0", Instruction_out, 32'd0);
        chk("rm_req0", {31'd0, imem_req}, 32'd0);
        freeze = 1'b0;
        cyc();
        rst = 1'b1;
        #1;
        chk("rm_addr_rst", imem_addr, 32'h0000_0000);
        chk("rm_req1", {31'd0, imem_req}, 32'd1);

        // Random phase against the reference model.
        salt = $urandom;
        for (int i = 0; i < 600; i++) begin
            imem_rdy     = ($urandom_range(0, 2) != 0);
            freeze       = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 19) == 0);
            branch_addr  = $urandom;
            cyc();
        end
        branch_taken = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
